mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port data/instruction RAM between instruction fetch (IF) and load/store (D).
//  Sequences each access through a small FSM and produces byte-lane write masks.
//  Sign-extends lb data and raises stall_o to the CPU until the pending access completes.
//  Sits between the CPU core (control/datapath) and the RAM macro.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  RD_LAT      1   RAM read latency in cycles, >=1; rdata valid RD_LAT cycles after mem_en_o
//  STARVE_MAX  4   consecutive D grants while IF waiting before IF is forced to win
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       reset, asynchronous, active-high
//  if_req_i     in   1       fetch request; held with if_addr_i until if_valid_o
//  if_addr_i    in   ADDR_W  fetch byte address (word access, [1:0] ignored)
//  if_rdata_o   out  32      fetched instruction, valid with if_valid_o
//  if_valid_o   out  1       one-cycle completion pulse for IF
//  d_req_i      in   1       load/store request; held with d_* fields until d_valid_o
//  d_we_i       in   1       1=store, 0=load (from memWrite_en)
//  d_word_i     in   1       1=word, 0=byte (from addrSelect)
//  d_addr_i     in   ADDR_W  data byte address
//  d_wdata_i    in   32      store data (byte stores use [7:0])
//  d_rdata_o    out  32      load data; lb sign-extended from selected lane
//  d_valid_o    out  1       one-cycle completion pulse for D
//  stall_o      out  1       = (d_req_i & ~d_valid_o) | (if_req_i & ~if_valid_o)
//  mem_en_o     out  1       RAM access strobe, one cycle per transaction
//  mem_we_o     out  4       byte write enables; 0 for reads
//  mem_addr_o   out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
//  mem_wdata_o  out  32      lane-replicated store data
//  mem_rdata_i  in   32      RAM read data
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs, captured request, read-data reg, starve_cnt = 0.
//    Reset mid-transaction aborts silently: no valid pulse.
//  - States: IDLE -> ISSUE -> (read: WAIT x RD_LAT) -> DONE -> IDLE; write skips WAIT.
//  - IDLE: sample requests and pick a winner; latch owner, addr, we, word, wdata. No request -> stay in IDLE.
//  - Arbitration: D wins unless (if_req_i && starve_cnt==STARVE_MAX), in which case IF wins.
//  - starve_cnt: +1 (saturating) on a D grant while if_req_i=1; cleared on an IF grant or when if_req_i=0 in IDLE.
//  - ISSUE: mem_en_o=1, mem_addr_o/mem_we_o/mem_wdata_o driven from latched request.
//  - WAIT: down-counter of RD_LAT; in last WAIT cycle capture mem_rdata_i into register.
//  - DONE: owner's valid_o=1 for exactly one cycle, rdata from register; next state IDLE.
//  - Latency from request sampled in IDLE (cycle 0): read valid at cycle 2+RD_LAT; write valid at cycle 2.
//  - Back-to-back: one IDLE bubble between transactions; min period 3+RD_LAT (rd) / 3 (wr).
//  - Byte store: mem_we_o = 4'b0001 << addr[1:0]; mem_wdata_o = {4{wdata[7:0]}}.
//  - Word store: mem_we_o = 4'b1111; wdata unchanged; addr[1:0] ignored, no misalign trap.
//  - Byte load: d_rdata_o = sign-extend(lane addr[1:0]); word load/fetch: full word.
//  - Outputs outside DONE: if_rdata_o/d_rdata_o hold last value; valids 0.
//  - mem_* outputs are 0 outside ISSUE.
//  - Request dropped mid-transaction: access still completes and valid still pulses.
//    The requester ignores the pulse.
//  - Simultaneous IF+D in IDLE: only one granted; loser stays pending and is sampled at next IDLE.
// STRUCTURE
//  - Package mem_arb_pkg: state_t enum {IDLE,ISSUE,WAIT,DONE}; owner_t {OWN_IF,OWN_D};
//    constants ACC_BYTE=1'b0, ACC_WORD=1'b1; 4-bit lane-mask type.
//  - Sub-module lsu_lane (combinational): addr[1:0], word, wdata, rdata
//    -> we mask, replicated wdata, extracted/sign-extended load data.
//  - Top holds FSM, latency counter, starve counter, request/response registers.
// TESTING
//  - Word load, RD_LAT=1: d_req addr=0x10, RAM[0x10]=0xDEADBEEF
//    -> mem_en cycle1, d_valid cycle3, d_rdata=0xDEADBEEF.
//  - Byte store addr=0x23, wdata=0x000000A5 -> mem_we=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x20, d_valid cycle2.
//  - Byte load addr=0x22, RAM[0x20]=0x0080FF00 -> d_rdata=0xFFFFFF80; addr=0x21 -> 0xFFFFFFFF.
//  - IF and D requests held continuously, STARVE_MAX=4 -> grant order D,D,D,D,IF,D,...; stall_o high throughout.
//  - Assert rst_i during WAIT -> next cycle IDLE, no valid pulse, all mem_* 0; fresh request then completes normally.
//  - RD_LAT=3 fetch addr=0x4 -> if_valid at cycle 5, stall_o deasserts same cycle as if_valid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory port arbiter
`timescale 1ns/1ps
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    localparam logic ACC_BYTE = 1'b0;
    localparam logic ACC_WORD = 1'b1;

    typedef logic [3:0] lane_mask_t;

    function automatic lane_mask_t byte_lane_mask(input logic [1:0] offset);
        return lane_mask_t'(4'b0001 << offset);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte-lane write mask, store replication and load extraction
`timescale 1ns/1ps
module lsu_lane
    import mem_arb_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic        i_word,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output lane_mask_t  o_we,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    // Word accesses pass straight through; byte accesses select one lane and sign-extend loads
    always_comb begin
        w_shifted = i_rdata >> {i_offset, 3'b000};
        o_we      = 4'b1111;
        o_wdata   = i_wdata;
        o_rdata   = i_rdata;
        if (i_word == ACC_BYTE) begin
            o_we    = byte_lane_mask(i_offset);
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter between instruction fetch and load/store
`timescale 1ns/1ps
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_rdata_o,
    output logic              if_valid_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic              d_word_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic [31:0]       d_rdata_o,
    output logic              d_valid_o,
    output logic              stall_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    state_t              r_state, w_next_state;
    owner_t              r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic                r_word;
    logic [31:0]         r_wdata;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [STV_W-1:0]    r_starve_cnt;
    logic [31:0]         r_if_rdata;
    logic [31:0]         r_d_rdata;

    logic                w_grant_if;
    logic                w_starved;
    lane_mask_t          w_lane_we;
    logic [31:0]         w_lane_wdata;
    logic [31:0]         w_load_data;

    // IF only beats a pending D request once it has lost STARVE_MAX times in a row
    assign w_starved  = (r_starve_cnt == STV_W'(STARVE_MAX));
    assign w_grant_if = if_req_i && (!d_req_i || w_starved);

    lsu_lane u_lsu_lane (
        .i_offset (r_addr[1:0]),
        .i_word   (r_word),
        .i_wdata  (r_wdata),
        .i_rdata  (mem_rdata_i),
        .o_we     (w_lane_we),
        .o_wdata  (w_lane_wdata),
        .o_rdata  (w_load_data)
    );

    // State register; reset aborts any transaction without a completion pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and per-state outputs; RAM strobes only live in ISSUE
    always_comb begin
        w_next_state = r_state;
        mem_en_o     = 1'b0;
        mem_we_o     = 4'b0000;
        mem_addr_o   = '0;
        mem_wdata_o  = 32'h0;
        if_valid_o   = 1'b0;
        d_valid_o    = 1'b0;
        case (r_state)
            IDLE:  if (if_req_i || d_req_i) w_next_state = ISSUE;
            ISSUE: begin
                mem_en_o     = 1'b1;
                mem_we_o     = r_we ? w_lane_we : 4'b0000;
                mem_addr_o   = {r_addr[ADDR_W-1:2], 2'b00};
                mem_wdata_o  = w_lane_wdata;
                w_next_state = r_we ? DONE : WAIT;
            end
            WAIT:  if (r_lat_cnt == '0) w_next_state = DONE;
            DONE: begin
                if_valid_o   = (r_owner == OWN_IF);
                d_valid_o    = (r_owner == OWN_D);
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign stall_o    = (d_req_i & ~d_valid_o) | (if_req_i & ~if_valid_o);
    assign if_rdata_o = r_if_rdata;
    assign d_rdata_o  = r_d_rdata;

    // Request capture, starvation tracking, latency countdown and read-data capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_owner      <= OWN_IF;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_word       <= ACC_BYTE;
            r_wdata      <= 32'h0;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_if_rdata   <= 32'h0;
            r_d_rdata    <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!if_req_i || w_grant_if)
                        r_starve_cnt <= '0;
                    else if (d_req_i && !w_starved)
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                    if (w_grant_if) begin
                        r_owner <= OWN_IF;
                        r_addr  <= if_addr_i;
                        r_we    <= 1'b0;
                        r_word  <= ACC_WORD;
                        r_wdata <= 32'h0;
                    end else if (d_req_i) begin
                        r_owner <= OWN_D;
                        r_addr  <= d_addr_i;
                        r_we    <= d_we_i;
                        r_word  <= d_word_i;
                        r_wdata <= d_wdata_i;
                    end
                end
                ISSUE: r_lat_cnt <= LAT_W'(RD_LAT - 1);
                WAIT: begin
                    if (r_lat_cnt == '0) begin
                        if (r_owner == OWN_IF) r_if_rdata <= mem_rdata_i;
                        else                   r_d_rdata  <= w_load_data;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // DUT with RD_LAT=1
    logic        if_req, if_valid, d_req, d_we, d_word, d_valid, stall, mem_en;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;

    // DUT with RD_LAT=3
    logic        if_req3, if_valid3, d_valid3, stall3, mem_en3;
    logic [31:0] if_addr3, if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic [3:0]  mem_we3;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.ADDR_W(32), .RD_LAT(1), .STARVE_MAX(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_valid_o(if_valid),
        .d_req_i(d_req), .d_we_i(d_we), .d_word_i(d_word), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_rdata_o(d_rdata), .d_valid_o(d_valid), .stall_o(stall),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .RD_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req3), .if_addr_i(if_addr3), .if_rdata_o(if_rdata3), .if_valid_o(if_valid3),
        .d_req_i(1'b0), .d_we_i(1'b0), .d_word_i(1'b0), .d_addr_i(32'h0),
        .d_wdata_i(32'h0), .d_rdata_o(d_rdata3), .d_valid_o(d_valid3), .stall_o(stall3),
        .mem_en_o(mem_en3), .mem_we_o(mem_we3), .mem_addr_o(mem_addr3),
        .mem_wdata_o(mem_wdata3), .mem_rdata_i(mem_rdata3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RAM model, 1-cycle read latency, contents reloaded while reset is held
    logic [31:0] ram1 [0:63];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 64; k++) ram1[k] <= 32'h0;
            ram1[1]   <= 32'h00112233;
            ram1[4]   <= 32'hDEADBEEF;
            ram1[8]   <= 32'h0080FF00;
            mem_rdata <= 32'h0;
        end else if (mem_en) begin
            mem_rdata <= ram1[mem_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram1[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // RAM model, 3-cycle read pipeline; data is only correct in the one cycle it is due
    logic [31:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= (mem_en3 && mem_addr3 == 32'h4) ? 32'hCAFEF00D : 32'h0BAD0BAD;
        p2 <= p1;
        p3 <= p2;
    end
    assign mem_rdata3 = p3;

    // Scoreboard: expected completions pushed at stimulus time, popped on valid pulses
    logic [32:0] d_q [$];
    logic [31:0] if_q [$];
    logic [31:0] if3_q [$];
    logic [32:0] d_e;
    logic [31:0] if_e;

    always @(negedge clk) begin
        if (!rst) begin
            if (d_valid) begin
                if (d_q.size() == 0) check("d_unexpected_valid", 32'(d_valid), 32'h0);
                else begin
                    d_e = d_q.pop_front();
                    if (d_e[32]) check("d_rdata", d_rdata, d_e[31:0]);
                end
            end
            if (if_valid) begin
                if (if_q.size() == 0) check("if_unexpected_valid", 32'(if_valid), 32'h0);
                else begin
                    if_e = if_q.pop_front();
                    check("if_rdata", if_rdata, if_e);
                end
            end
            if (if_valid3) begin
                if (if3_q.size() == 0) check("if3_unexpected_valid", 32'(if_valid3), 32'h0);
                else begin
                    if_e = if3_q.pop_front();
                    check("if3_rdata", if_rdata3, if_e);
                end
            end
            if (d_valid3) check("d3_unexpected_valid", 32'(d_valid3), 32'h0);
        end
    end

    // One transaction on the RD_LAT=1 DUT, driven from a negedge in IDLE
    task automatic access(input bit is_if, input logic we, input logic word,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic [3:0] exp_we,
                          input logic [31:0] exp_wdata);
        int  n;
        int  lat;
        bit  done;
        lat = we ? 2 : 3;
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
            if_q.push_back(exp_rdata);
        end else begin
            d_req = 1'b1; d_we = we; d_word = word; d_addr = addr; d_wdata = wdata;
            d_q.push_back({~we, exp_rdata});
        end
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("mem_en_issue", 32'(mem_en), 32'h1);
                check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check("mem_we", 32'(mem_we), 32'(exp_we));
                if (we) check("mem_wdata", mem_wdata, exp_wdata);
            end
            if (n == 2) check("mem_en_after_issue", 32'(mem_en), 32'h0);
            check("stall", 32'(stall), (n == lat) ? 32'h0 : 32'h1);
            if (d_valid || if_valid) begin
                check("owner", 32'({if_valid, d_valid}), is_if ? 32'h2 : 32'h1);
                check("latency", 32'(n), 32'(lat));
                done = 1'b1;
            end
        end
        if (!done) check("access_timeout", 32'h0, 32'h1);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int got;
        bit seen;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_word = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        if_req3 = 1'b0; if_addr3 = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_valids", 32'({if_valid, d_valid}), 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        access(1'b0, 1'b0, 1'b1, 32'h10, 32'h0,        32'hDEADBEEF, 4'b0000, 32'h0);
        access(1'b0, 1'b0, 1'b0, 32'h22, 32'h0,        32'hFFFFFF80, 4'b0000, 32'h0);
        access(1'b0, 1'b0, 1'b0, 32'h20, 32'h0,        32'h00000000, 4'b0000, 32'h0);
        access(1'b0, 1'b0, 1'b0, 32'h21, 32'h0,        32'hFFFFFFFF, 4'b0000, 32'h0);
        access(1'b0, 1'b1, 1'b0, 32'h23, 32'h000000A5, 32'h0,        4'b1000, 32'hA5A5A5A5);
        check("d_rdata_hold_after_store", d_rdata, 32'hFFFFFFFF);
        access(1'b0, 1'b0, 1'b1, 32'h20, 32'h0,        32'hA580FF00, 4'b0000, 32'h0);
        access(1'b0, 1'b0, 1'b0, 32'h23, 32'h0,        32'hFFFFFFA5, 4'b0000, 32'h0);
        access(1'b0, 1'b1, 1'b1, 32'h31, 32'h12345678, 32'h0,        4'b1111, 32'h12345678);
        access(1'b0, 1'b0, 1'b1, 32'h30, 32'h0,        32'h12345678, 4'b0000, 32'h0);
        access(1'b1, 1'b0, 1'b1, 32'h6,  32'h0,        32'h00112233, 4'b0000, 32'h0);

        // Both requesters held: D wins four times, then the starved fetch is forced through
        if_req = 1'b1; if_addr = 32'h4;
        d_req = 1'b1; d_we = 1'b0; d_word = 1'b1; d_addr = 32'h10;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) if_q.push_back(32'h00112233);
            else            d_q.push_back({1'b1, 32'hDEADBEEF});
        end
        got = 0;
        n = 0;
        while (got < 10 && n < 200) begin
            @(negedge clk);
            n++;
            check("starve_stall", 32'(stall), 32'h1);
            if (d_valid || if_valid) begin
                check("grant_order", 32'({if_valid, d_valid}), (got % 5 == 4) ? 32'h2 : 32'h1);
                got++;
            end
        end
        if (got < 10) check("starve_timeout", 32'(got), 32'd10);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);

        // Reset in the WAIT cycle of a load aborts it with no completion pulse
        d_req = 1'b1; d_we = 1'b0; d_word = 1'b1; d_addr = 32'h10;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_mem_en", 32'(mem_en), 32'h0);
        check("abort_mem_we", 32'(mem_we), 32'h0);
        check("abort_mem_addr", mem_addr, 32'h0);
        check("abort_d_rdata", d_rdata, 32'h0);
        rst = 1'b0;
        d_req = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (d_valid) seen = 1'b1;
        end
        check("abort_no_valid", 32'(seen), 32'h0);
        access(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 4'b0000, 32'h0);

        // RD_LAT=3 fetch completes in cycle 5, stall drops in that same cycle
        if_req3 = 1'b1; if_addr3 = 32'h4;
        if3_q.push_back(32'hCAFEF00D);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("lat3_mem_en", 32'(mem_en3), 32'h1);
                check("lat3_mem_addr", mem_addr3, 32'h4);
            end
            check("lat3_stall", 32'(stall3), (n == 5) ? 32'h0 : 32'h1);
            if (if_valid3) begin
                check("lat3_latency", 32'(n), 32'd5);
                seen = 1'b1;
            end
        end
        if (!seen) check("lat3_timeout", 32'h0, 32'h1);
        if_req3 = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard_d_empty", 32'(d_q.size()), 32'h0);
        check("scoreboard_if_empty", 32'(if_q.size() + if3_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
